// File: rtl/demux1_2_buf.sv
// demux1_2_buf: steers one WIDTH-bit source stream into one of two
// independently buffered output channels. Each channel owns a small FIFO
// with a valid/ready handshake, so a stalled consumer on one channel never
// blocks words already accepted for the other.
module demux1_2_buf #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       sel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           data_out1,
   output logic [WIDTH-1:0]           data_out0,
   output logic                       valid1,
   output logic                       valid0,
   input  logic                       ready1,
   input  logic                       ready0,
   output logic [$clog2(DEPTH):0]     count1,
   output logic [$clog2(DEPTH):0]     count0,
   output logic [7:0]                 routed1,
   output logic [7:0]                 routed0
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Index 1 is channel 1, index 0 is channel 0 throughout.
   logic [WIDTH-1:0] mem    [2][DEPTH];
   logic [PTR_W-1:0] wr_ptr [2];
   logic [PTR_W-1:0] rd_ptr [2];
   logic [CNT_W-1:0] cnt    [2];
   logic [7:0]       routed [2];

   logic [1:0] vld;
   logic [1:0] push;
   logic [1:0] pop;

   // Handshake decode; in_ready looks only at sel and registered occupancy,
   // so a full channel stays closed even if it pops in the same cycle.
   assign vld[1]   = (cnt[1] != '0);
   assign vld[0]   = (cnt[0] != '0);
   assign in_ready = sel ? (cnt[1] != CNT_FULL) : (cnt[0] != CNT_FULL);
   assign push[1]  = in_valid & in_ready & sel;
   assign push[0]  = in_valid & in_ready & ~sel;
   assign pop[1]   = vld[1] & ready1;
   assign pop[0]   = vld[0] & ready0;

   // Per-channel FIFO state: storage, pointers, occupancy and push counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem[k][i] <= '0;
            end
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            cnt[k]    <= '0;
            routed[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
               mem[k][wr_ptr[k]] <= data_in;
               wr_ptr[k]         <= wr_ptr[k] + PTR_ONE;
               routed[k]         <= routed[k] + 8'd1;
            end
            if (pop[k]) begin
               rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
            end
            case ({push[k], pop[k]})
               2'b10:   cnt[k] <= cnt[k] + CNT_ONE;
               2'b01:   cnt[k] <= cnt[k] - CNT_ONE;
               default: cnt[k] <= cnt[k];
            endcase
         end
      end
   end

   // Head words are forced to zero while a channel is empty.
   assign data_out1 = vld[1] ? mem[1][rd_ptr[1]] : '0;
   assign data_out0 = vld[0] ? mem[0][rd_ptr[0]] : '0;
   assign valid1    = vld[1];
   assign valid0    = vld[0];
   assign count1    = cnt[1];
   assign count0    = cnt[0];
   assign routed1   = routed[1];
   assign routed0   = routed[0];

endmodule

// File: tb/tb_demux1_2_buf.sv
// Self-checking bench for demux1_2_buf. A queue-per-channel reference model
// tracks the expected contents; each scenario task compares DUT outputs.
module tb_demux1_2_buf;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_out1;
   logic [WIDTH-1:0] data_out0;
   logic             valid1;
   logic             valid0;
   logic             ready1;
   logic             ready0;
   logic [1:0]       count1;
   logic [1:0]       count0;
   logic [7:0]       routed1;
   logic [7:0]       routed0;

   int total = 0;
   int bad   = 0;

   // Reference model: one queue per channel plus push totals.
   logic [WIDTH-1:0] q1[$];
   logic [WIDTH-1:0] q0[$];
   int               r1 = 0;
   int               r0 = 0;

   demux1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .data_out1(data_out1), .data_out0(data_out0),
      .valid1(valid1), .valid0(valid0), .ready1(ready1), .ready0(ready0),
      .count1(count1), .count0(count0), .routed1(routed1), .routed0(routed0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and apply the same edge to the model.
   task automatic tick();
      bit a1, a0, p1, p0;
      logic [WIDTH-1:0] d;
      a1 = in_valid && sel && (q1.size() != DEPTH);
      a0 = in_valid && !sel && (q0.size() != DEPTH);
      p1 = ready1 && (q1.size() != 0);
      p0 = ready0 && (q0.size() != 0);
      d  = data_in;
      @(posedge clk);
      if (rst) begin
         q1.delete(); q0.delete(); r1 = 0; r0 = 0;
      end else begin
         if (p1) void'(q1.pop_front());
         if (p0) void'(q0.pop_front());
         if (a1) begin q1.push_back(d); r1++; end
         if (a0) begin q0.push_back(d); r0++; end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; ready1 = 1'b0; ready0 = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; ready1 = 1'b0; ready0 = 1'b0;
      sel = 1'b0; data_in = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (count1 !== 2'd0 || count0 !== 2'd0) begin bad++;
         $display("FAIL reset_count got %0d/%0d want 0/0", count1, count0); end
      total++; if (valid1 !== 1'b0 || valid0 !== 1'b0) begin bad++;
         $display("FAIL reset_valid got %b/%b want 0/0", valid1, valid0); end
      total++; if (data_out1 !== 16'd0 || data_out0 !== 16'd0) begin bad++;
         $display("FAIL reset_data got %h/%h want 0/0", data_out1, data_out0); end
      total++; if (routed1 !== 8'd0 || routed0 !== 8'd0) begin bad++;
         $display("FAIL reset_routed got %0d/%0d want 0/0", routed1, routed0); end
      sel = 1'b1; #1;
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL reset_rdy_sel1 got %b want 1", in_ready); end
      sel = 1'b0; #1;
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL reset_rdy_sel0 got %b want 1", in_ready); end
   endtask

   task automatic test_basic_routing();
      ready1 = 1'b0; ready0 = 1'b0;
      in_valid = 1'b1; sel = 1'b1; data_in = 16'd5; tick();
      sel = 1'b0; data_in = 16'd4; tick();
      in_valid = 1'b0;
      total++; if (data_out1 !== 16'd5 || valid1 !== 1'b1) begin bad++;
         $display("FAIL basic_ch1 got %0d v%b want 5 v1", data_out1, valid1); end
      total++; if (data_out0 !== 16'd4 || valid0 !== 1'b1) begin bad++;
         $display("FAIL basic_ch0 got %0d v%b want 4 v1", data_out0, valid0); end
      total++; if (count1 !== 2'd1 || count0 !== 2'd1) begin bad++;
         $display("FAIL basic_count got %0d/%0d want 1/1", count1, count0); end
      total++; if (routed1 !== 8'd1 || routed0 !== 8'd1) begin bad++;
         $display("FAIL basic_routed got %0d/%0d want 1/1", routed1, routed0); end
   endtask

   task automatic test_full_stall();
      do_reset();
      in_valid = 1'b1; sel = 1'b1; data_in = 16'd6; tick();
      data_in = 16'd7; tick();
      in_valid = 1'b0; #1;
      total++; if (count1 !== 2'd2) begin bad++;
         $display("FAIL stall_count1 got %0d want 2", count1); end
      sel = 1'b1; #1;
      total++; if (in_ready !== 1'b0) begin bad++;
         $display("FAIL stall_rdy_sel1 got %b want 0", in_ready); end
      sel = 1'b0; #1;
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL stall_rdy_sel0 got %b want 1", in_ready); end
      in_valid = 1'b1; data_in = 16'd9; tick();
      in_valid = 1'b0;
      total++; if (data_out0 !== 16'd9 || count0 !== 2'd1) begin bad++;
         $display("FAIL stall_push_ch0 got %0d c%0d want 9 c1", data_out0, count0); end
      total++; if (data_out1 !== 16'd6 || count1 !== 2'd2) begin bad++;
         $display("FAIL stall_ch1_hold got %0d c%0d want 6 c2", data_out1, count1); end
   endtask

   task automatic test_full_pop();
      // channel 1 holds 6,7 from the previous scenario
      ready1 = 1'b1; in_valid = 1'b1; sel = 1'b1; data_in = 16'd8; #1;
      total++; if (in_ready !== 1'b0) begin bad++;
         $display("FAIL fullpop_rdy got %b want 0", in_ready); end
      tick();
      total++; if (data_out1 !== 16'd7 || count1 !== 2'd1) begin bad++;
         $display("FAIL fullpop_first got %0d c%0d want 7 c1", data_out1, count1); end
      total++; if (in_ready !== 1'b1) begin bad++;
         $display("FAIL fullpop_rdy2 got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      total++; if (data_out1 !== 16'd8 || count1 !== 2'd1 || routed1 !== 8'd3) begin bad++;
         $display("FAIL fullpop_second got %0d c%0d r%0d want 8 c1 r3", data_out1, count1, routed1); end
      tick();
      ready1 = 1'b0;
      total++; if (valid1 !== 1'b0 || data_out1 !== 16'd0 || count1 !== 2'd0) begin bad++;
         $display("FAIL fullpop_empty got v%b %0d c%0d want v0 0 c0", valid1, data_out1, count1); end
   endtask

   task automatic test_wrap();
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      bit acc;
      do_reset();
      while (recv < 600 && cyc < 5000) begin
         in_valid = (sent < 600); sel = 1'b0; data_in = sent[15:0];
         ready0 = 1'($urandom_range(0, 1)); ready1 = 1'b0;
         #1;
         if (in_valid) begin
            total++; if (in_ready !== (q0.size() != DEPTH)) begin bad++;
               $display("FAIL wrap_rdy cyc=%0d got %b want %b", cyc, in_ready, (q0.size() != DEPTH)); end
         end
         if (valid0 && ready0) begin
            total++; if (data_out0 !== recv[15:0]) begin bad++;
               $display("FAIL wrap_data idx=%0d got %0d want %0d", recv, data_out0, recv); end
            recv++;
         end
         acc = in_valid && (q0.size() != DEPTH);
         tick();
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0; ready0 = 1'b0;
      total++; if (recv != 600) begin bad++;
         $display("FAIL wrap_timeout got %0d words want 600", recv); end
      total++; if (routed0 !== 8'd88 || routed0 !== 8'(r0 % 256)) begin bad++;
         $display("FAIL wrap_routed got %0d want 88", routed0); end
      total++; if (count0 !== 2'd0 || valid0 !== 1'b0) begin bad++;
         $display("FAIL wrap_drained got c%0d v%b want c0 v0", count0, valid0); end
   endtask

   task automatic test_independent();
      int recv = 0;
      do_reset();
      in_valid = 1'b1; sel = 1'b1; data_in = 16'hA1; tick();
      data_in = 16'hA2; tick();
      for (int i = 0; i < 14; i++) begin
         in_valid = (i < 10); sel = 1'b0; data_in = 16'h100 + 16'(i);
         ready0 = 1'b1; ready1 = 1'b0;
         #1;
         if (in_valid) begin
            total++; if (in_ready !== 1'b1) begin bad++;
               $display("FAIL indep_rdy i=%0d got %b want 1", i, in_ready); end
         end
         if (valid0 && ready0) begin
            total++; if (data_out0 !== 16'h100 + 16'(recv)) begin bad++;
               $display("FAIL indep_data idx=%0d got %h want %h", recv, data_out0, 16'h100 + 16'(recv)); end
            recv++;
         end
         tick();
      end
      in_valid = 1'b0; ready0 = 1'b0;
      total++; if (recv != 10) begin bad++;
         $display("FAIL indep_recv got %0d want 10", recv); end
      total++; if (data_out1 !== 16'hA1 || count1 !== 2'd2 || routed1 !== 8'd2) begin bad++;
         $display("FAIL indep_ch1 got %h c%0d r%0d want a1 c2 r2", data_out1, count1, routed1); end
      ready1 = 1'b1; tick(); ready1 = 1'b0;
      total++; if (data_out1 !== 16'hA2) begin bad++;
         $display("FAIL indep_ch1_second got %h want a2", data_out1); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] e1, e0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1));
         data_in  = 16'($urandom); ready1 = 1'($urandom_range(0, 1));
         ready0   = 1'($urandom_range(0, 1));
         tick();
         e1 = (q1.size() != 0) ? q1[0] : '0;
         e0 = (q0.size() != 0) ? q0[0] : '0;
         total++;
         if (data_out1 !== e1 || data_out0 !== e0 || valid1 !== (q1.size() != 0) ||
             valid0 !== (q0.size() != 0) || count1 !== 2'(q1.size()) || count0 !== 2'(q0.size()) ||
             routed1 !== 8'(r1 % 256) || routed0 !== 8'(r0 % 256)) begin
            bad++;
            $display("FAIL random i=%0d got d%h/%h c%0d/%0d r%0d/%0d want d%h/%h c%0d/%0d r%0d/%0d",
                     i, data_out1, data_out0, count1, count0, routed1, routed0,
                     e1, e0, q1.size(), q0.size(), r1 % 256, r0 % 256);
         end
      end
      in_valid = 1'b0; ready1 = 1'b0; ready0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1; sel = 1'b1; data_in = 16'h11; tick();
      sel = 1'b0; data_in = 16'h22; tick();
      total++; if (valid1 !== 1'b1 || valid0 !== 1'b1) begin bad++;
         $display("FAIL midrst_pre got v%b/%b want 1/1", valid1, valid0); end
      data_in = 16'h55; rst = 1'b1; tick();
      rst = 1'b0; in_valid = 1'b0;
      total++; if (count1 !== 2'd0 || count0 !== 2'd0 || valid1 !== 1'b0 || valid0 !== 1'b0) begin bad++;
         $display("FAIL midrst_state got c%0d/%0d v%b/%b want 0", count1, count0, valid1, valid0); end
      total++; if (data_out1 !== 16'd0 || data_out0 !== 16'd0) begin bad++;
         $display("FAIL midrst_data got %h/%h want 0/0", data_out1, data_out0); end
      total++; if (routed1 !== 8'd0 || routed0 !== 8'd0) begin bad++;
         $display("FAIL midrst_routed got %0d/%0d want 0/0", routed1, routed0); end
      tick();
      total++; if (count0 !== 2'd0 || valid0 !== 1'b0) begin bad++;
         $display("FAIL midrst_dropped got c%0d v%b want c0 v0", count0, valid0); end
   endtask

   initial begin
      test_reset();
      test_basic_routing();
      test_full_stall();
      test_full_pop();
      test_wrap();
      test_independent();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux1_2_buf.md
# demux1_2_buf

Buffered 1-to-2 demultiplexer for the 16-bit pocket calculator datapath. It performs the reverse of the 2:1 data multiplexer: one 16-bit source stream is steered by `sel` into one of two independent output channels. Each channel has its own FIFO and a valid/ready handshake, so a stalled destination never blocks words bound for the other channel once they are accepted. It sits between the ALU/result bus and the two write-back consumers (register file port and display/output latch).

## Interface
- `WIDTH`, 16, data word width.
- `DEPTH`, 2, entries per channel FIFO; power of two, at least 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous reset, active-high.
- `data_in`  in  WIDTH  word to route.
- `sel`  in  1  destination: 1 selects channel 1, 0 selects channel 0.
- `in_valid`  in  1  `data_in`/`sel` are valid.
- `in_ready`  out  1  the selected channel can accept this cycle.
- `data_out1`, `data_out0`  out  WIDTH  head word of channel 1 / channel 0.
- `valid1`, `valid0`  out  1  the channel FIFO is non-empty.
- `ready1`, `ready0`  in  1  the consumer takes the head word.
- `count1`, `count0`  out  log2(DEPTH)+1  channel occupancy.
- `routed1`, `routed0`  out  8  words accepted per channel, modulo 256.

## Operation
- Push: `in_valid & in_ready` at a rising edge writes `data_in` into the FIFO selected by `sel`. The other FIFO is untouched.
- `in_ready` is combinational from `sel` and the registered occupancy only: `in_ready = (count_sel != DEPTH)`. It never depends on `ready1`/`ready0`.
- Pop: `valid_k & ready_k` at a rising edge removes the head word of channel k. Channels pop independently, and both may pop in the same cycle.
- Occupancy update per channel:
  - push only: +1.
  - pop only: -1.
  - push and pop together on a non-full channel: unchanged, and the order is preserved.
- A full channel holds `in_ready` low for that `sel` even when the same channel pops in that cycle. There is no same-cycle pass-through.
- `valid_k = (count_k != 0)`.
- `data_out_k` is the entry at the read pointer when `valid_k` is high. It is forced to 0 when the channel is empty.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH without a gap.
- `routed_k` increments on each push to channel k and wraps from 255 to 0.
- Changing `sel` while `in_valid` is high and `in_ready` is low is legal. `in_ready` re-evaluates for the new channel in the same cycle.
- Ready without valid, or valid without ready, has no effect on state.

## Timing
- Reset values, taking effect at the first rising edge with `rst` high: all pointers 0, `count1 = count0 = 0`, `routed1 = routed0 = 0`, `valid1 = valid0 = 0`, `data_out1 = data_out0 = 0`, storage cleared to 0.
- `in_ready` reads 1 for either `sel` in the cycle after reset is released.
- Reset asserted mid-operation overrides any push or pop in that cycle. All buffered words are discarded.
- Latency: a word accepted at edge N shows on `data_out_k` with `valid_k = 1` immediately after edge N, so it is consumable at edge N+1.
- Throughput: one push per cycle. Up to two pops per cycle, one per channel.
- Outputs `valid_k`, `data_out_k`, `count_k` and `routed_k` are registered or decoded from registered state only. No combinational path runs from `data_in`/`in_valid` to these outputs.

## Test plan
- **Reset and basic routing.** Assert reset, then push 5 with `sel = 1` and 4 with `sel = 0` on consecutive cycles with both ready signals low. Expect `data_out1 = 5`, `valid1 = 1`, `data_out0 = 4`, `valid0 = 1`, `count1 = count0 = 1`, `routed1 = routed0 = 1`.
- **Full stall.** With `ready1 = 0`, push 6 and 7 to channel 1. Expect `count1 = 2` and `in_ready = 0` for `sel = 1` while `in_ready = 1` for `sel = 0`. A push of 9 to channel 0 still succeeds.
- **Full with simultaneous pop.** With channel 1 full, hold `ready1 = 1` and present `in_valid` with `sel = 1`. Expect the first cycle to pop 6 only, with `in_ready = 0`. The next cycle accepts the new word, and the output order is 6, 7, new.
- **Wrap-around.** Stream 600 words 0..599 into channel 0 with `ready0` toggling pseudo-randomly. Expect the output sequence to be exactly 0..599 with no loss or duplication, and `routed0 = 600 mod 256 = 88`.
- **Independent channels.** Hold channel 1 stalled and full while 10 words flow through channel 0 with `ready0 = 1`. Expect all 10 to arrive in order and channel 1 contents to be unchanged.
- **Reset mid-operation.** With both channels holding data, assert `rst` for one cycle during a push. Expect the word to be dropped, all counts and valids 0, both `data_out` 0, and `routed` 0.
